// File: rtl/main_pkg.sv
// Shared BCD digit type and the single-digit increment helper used by the
// digit registers and by the LED next-value logic in bcd_main.
package main_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  typedef struct packed {
    bcd_digit_t digit;
    logic       carry;
  } bcd_inc_t;

  // Codes 9..F all roll to 0 with carry so a corrupted digit self-heals on the next tick.
  function automatic bcd_inc_t bcd_inc(input bcd_digit_t d, input logic inc);
    bcd_inc_t r;
    r.digit = d;
    r.carry = 1'b0;
    if (inc) begin
      if (d >= BCD_MAX) begin
        r.digit = 4'd0;
        r.carry = 1'b1;
      end else begin
        r.digit = d + 4'd1;
        r.carry = 1'b0;
      end
    end else begin
      r.digit = d;
      r.carry = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decimal digit register: advances on inc_i, emits carry_o when it rolls
// over to 0.
module bcd_digit
  import main_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       inc_i,
  output bcd_digit_t digit_o,
  output logic       carry_o
);

  bcd_digit_t digit_q;
  bcd_digit_t digit_d;
  bcd_inc_t   nxt_s;

  assign nxt_s   = bcd_inc(digit_q, inc_i);
  assign digit_d = nxt_s.digit;
  assign carry_o = nxt_s.carry;
  assign digit_o = digit_q;

  // Digit state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      digit_q <= 4'd0;
    end else begin
      digit_q <= digit_d;
    end
  end

endmodule

// File: rtl/bcd_main.sv
// Free-running 00..99 BCD heartbeat counter on an 8-LED bank, one step every
// 2**DIV clocks. Optional macro MAIN_ACTIVE_LOW_LEDS_EN inverts the LED bank.
module bcd_main
  import main_pkg::*;
#(
  parameter int unsigned DIV = 22
) (
  input  logic       CLK,
  input  logic       RST_N,
  output logic [7:0] LEDS
);

`ifdef MAIN_ACTIVE_LOW_LEDS_EN
  localparam logic [7:0] LED_MASK = 8'hFF;
`else
  localparam logic [7:0] LED_MASK = 8'h00;
`endif

  localparam logic [DIV-1:0] PRESC_ONE = DIV'(1);

  logic [DIV-1:0] presc_q;
  logic [DIV-1:0] presc_d;
  logic           tick_s;

  bcd_digit_t ones_s;
  bcd_digit_t tens_s;
  logic       ones_carry_s;
  logic       tens_carry_s;
  bcd_inc_t   ones_nxt_s;
  bcd_inc_t   tens_nxt_s;

  logic [7:0] leds_q;
  logic [7:0] leds_d;

  assign presc_d = presc_q + PRESC_ONE;
  assign tick_s  = &presc_q;

  // Prescaler wraps naturally at 2**DIV-1 -> 0.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  bcd_digit u_ones (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .inc_i   (tick_s),
    .digit_o (ones_s),
    .carry_o (ones_carry_s)
  );

  bcd_digit u_tens (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .inc_i   (ones_carry_s),
    .digit_o (tens_s),
    .carry_o (tens_carry_s)
  );

  // LEDS loads the digits' next values so it changes on the same edge as they do.
  always_comb begin
    ones_nxt_s = bcd_inc(ones_s, tick_s);
    tens_nxt_s = bcd_inc(tens_s, ones_carry_s);
    leds_d     = {tens_nxt_s.digit, ones_nxt_s.digit} ^ LED_MASK;
  end

  // LED output register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      leds_q <= LED_MASK;
    end else begin
      leds_q <= leds_d;
    end
  end

  assign LEDS = leds_q;

endmodule

// File: tb/tb_bcd_main.sv
// Self-checking bench for bcd_main at DIV=3 (one count every 8 clocks), using
// a decimal reference count and a scoreboard queue of per-clock LED values.
module tb_bcd_main;

`ifdef MAIN_ACTIVE_LOW_LEDS_EN
  localparam logic [7:0] LED_MASK = 8'hFF;
`else
  localparam logic [7:0] LED_MASK = 8'h00;
`endif

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [7:0] LEDS;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt_m    = 0;
  int presc_m  = 0;
  logic [7:0] exp_q[$];

  bcd_main #(.DIV(3)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .LEDS  (LEDS)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] enc(input int c);
    logic [3:0] t;
    logic [3:0] o;
    t = 4'(c / 10);
    o = 4'(c % 10);
    return {t, o} ^ LED_MASK;
  endfunction

  // Advance n clocks; the model predicts each LED value, pushes it, then the sample pops it.
  task automatic step(input int n);
    logic [7:0] exp_v;
    logic [7:0] raw;
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      if (RST_N) begin
        if (presc_m == 7) cnt_m = (cnt_m + 1) % 100;
        presc_m = (presc_m + 1) % 8;
      end
      exp_q.push_back(enc(cnt_m));
      #1;
      exp_v = exp_q.pop_front();
      n_checks++;
      if (LEDS !== exp_v) begin
        n_fail++;
        $display("FAIL scoreboard t=%0t LEDS=%h expected=%h", $time, LEDS, exp_v);
      end
      raw = LEDS ^ LED_MASK;
      n_checks++;
      if (raw[7:4] > 4'd9 || raw[3:0] > 4'd9) begin
        n_fail++;
        $display("FAIL nibble_range t=%0t LEDS=%h required digits <= 9", $time, LEDS);
      end
    end
  endtask

  task automatic hold_reset(input int n);
    RST_N   = 1'b0;
    cnt_m   = 0;
    presc_m = 0;
    #1;
    n_checks++;
    if (LEDS !== LED_MASK) begin
      n_fail++;
      $display("FAIL reset_value LEDS=%h expected=%h", LEDS, LED_MASK);
    end
    step(n);
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic expect_leds(input string name, input logic [7:0] req);
    n_checks++;
    if (LEDS !== req) begin
      n_fail++;
      $display("FAIL %s LEDS=%h expected=%h", name, LEDS, req);
    end
  endtask

  task automatic test_reset();
    hold_reset(5);
    step(3);
    #2;
    RST_N = 1'b0;
    #1;
    expect_leds("async_reset", 8'h00 ^ LED_MASK);
  endtask

  task automatic test_first_tick();
    hold_reset(2);
    step(7);
    expect_leds("before_first_tick", 8'h00 ^ LED_MASK);
    step(1);
    expect_leds("first_tick", 8'h01 ^ LED_MASK);
  endtask

  task automatic test_carry();
    hold_reset(2);
    step(80);
    expect_leds("ones_carry", 8'h10 ^ LED_MASK);
  endtask

  task automatic test_wrap();
    hold_reset(2);
    step(800);
    expect_leds("wrap_99_00", 8'h00 ^ LED_MASK);
    step(8);
    expect_leds("after_wrap", 8'h01 ^ LED_MASK);
  endtask

  task automatic test_mid_reset();
    hold_reset(2);
    step(400);
    expect_leds("count_50", 8'h50 ^ LED_MASK);
    #2;
    RST_N   = 1'b0;
    cnt_m   = 0;
    presc_m = 0;
    #1;
    expect_leds("mid_count_reset", 8'h00 ^ LED_MASK);
    @(negedge CLK);
    RST_N = 1'b1;
    step(8);
    expect_leds("restart_after_reset", 8'h01 ^ LED_MASK);
  endtask

  task automatic test_led_polarity();
    RST_N = 1'b0;
    #1;
    expect_leds("polarity_in_reset", LED_MASK);
    hold_reset(2);
    step(80);
    expect_leds("polarity_count_10", 8'h10 ^ LED_MASK);
  endtask

  initial begin
    test_reset();
    test_first_tick();
    test_carry();
    test_wrap();
    test_mid_reset();
    test_led_polarity();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain left=%0d expected=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
